mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 91 +++++++++
 tb/tb_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: CPU/debug requester ports, memory port and status bundle for mem_port_arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic              cpu_stall;
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] mem0_q;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_ack, cpu_stall, dbg_ack, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output mem0_q, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_ack, cpu_stall, dbg_ack, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  mem0_q, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one sync data-memory port between CPU and debug requesters, one access per 3 cycles.
// ARB_ROUND_ROBIN_EN defined: ties alternate owners; undefined: CPU wins every tie.
module mem_port_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_own_dbg;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_mem0;
    logic              w_any_req;
    logic              w_grant_dbg;
    logic              w_take;
    logic              w_cpu_ack;

    assign w_any_req = bus.cpu_req | bus.dbg_req;
    assign w_take    = (r_state == IDLE) & w_any_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_dbg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last_dbg <= 1'b1;
        else if (w_take)
            r_last_dbg <= w_grant_dbg;
    end

    assign w_grant_dbg = bus.dbg_req & (~bus.cpu_req | ~r_last_dbg);
`else
    assign w_grant_dbg = bus.dbg_req & ~bus.cpu_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE)  ? (w_any_req ? ISSUE : IDLE) :
                 (r_state == ISSUE) ? RESP : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_own_dbg <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else if (w_take) begin
            r_own_dbg <= w_grant_dbg;
            r_we      <= w_grant_dbg ? bus.dbg_we    : bus.cpu_we;
            r_addr    <= w_grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
            r_wdata   <= w_grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
        end
    end

    // Word 0 shadow follows writes as they commit to memory, whoever issued them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mem0 <= '0;
        else if ((r_state == ISSUE) && r_we && (r_addr == '0))
            r_mem0 <= r_wdata;
    end

    assign w_cpu_ack = (r_state == RESP) & ~r_own_dbg;

    always_comb begin
        bus.mem_en    = (r_state == ISSUE);
        bus.mem_we    = (r_state == ISSUE) & r_we;
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
        bus.cpu_ack   = w_cpu_ack;
        bus.dbg_ack   = (r_state == RESP) & r_own_dbg;
        bus.rdata     = (r_state == RESP) ? bus.mem_rdata : '0;
        bus.busy      = (r_state != IDLE);
        bus.cpu_stall = bus.cpu_req & ~w_cpu_ack;
        bus.mem0_q    = r_mem0;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a behavioural synchronous memory.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    typedef struct {
        bit          dbg;
        bit          we;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem[128];
    logic [31:0] mem[128];

    mem_port_arbiter_if #(.ADDR_W(7), .DATA_W(32)) bus();

    mem_port_arbiter #(.ADDR_W(7), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic push_exp(input bit dbg, input bit we, input logic [6:0] a, input logic [31:0] d);
        exp_t e;
        if (we) ref_mem[a] = d;
        e.dbg = dbg;
        e.we = we;
        e.rdata = we ? 32'h0 : ref_mem[a];
        sb.push_back(e);
    endtask

    task automatic run_access(input bit dbg, input bit we, input logic [6:0] a, input logic [31:0] d,
                              output int lat, output logic [31:0] rd, output int en_cnt, output int other);
        @(negedge clk);
        if (dbg) begin
            bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        end
        lat = -1; rd = 'x; en_cnt = 0; other = 0;
        for (int i = 1; i <= 10 && lat < 0; i++) begin
            @(negedge clk);
            if (bus.mem_en) en_cnt++;
            if (dbg ? bus.cpu_ack : bus.dbg_ack) other++;
            if (dbg ? bus.dbg_ack : bus.cpu_ack) begin
                lat = i;
                rd = bus.rdata;
            end
        end
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_run++; if (bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got %b want 0", bus.mem_en); end
        n_run++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b want 0", bus.mem_we); end
        n_run++; if (bus.mem_addr !== 7'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
        n_run++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata); end
        n_run++; if ({bus.cpu_ack, bus.dbg_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_acks got %b want 00", {bus.cpu_ack, bus.dbg_ack}); end
        n_run++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_run++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", bus.rdata); end
        n_run++; if (bus.mem0_q !== 32'h0) begin n_fail++; $display("FAIL reset_mem0_q got %h want 0", bus.mem0_q); end
        n_run++; if (bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.cpu_stall); end
        rst_n = 1'b1;
    endtask

    task automatic test_cpu_rw();
        int lat, en_cnt, other;
        logic [31:0] rd;
        exp_t e;
        push_exp(1'b0, 1'b1, 7'h05, 32'hDEADBEEF);
        run_access(1'b0, 1'b1, 7'h05, 32'hDEADBEEF, lat, rd, en_cnt, other);
        e = sb.pop_front();
        n_run++; if (lat !== 2) begin n_fail++; $display("FAIL cpu_wr_latency got %0d want 2", lat); end
        n_run++; if (en_cnt !== 1) begin n_fail++; $display("FAIL cpu_wr_mem_en_cycles got %0d want 1", en_cnt); end
        n_run++; if (other !== 0) begin n_fail++; $display("FAIL cpu_wr_dbg_ack got %0d want 0", other); end
        push_exp(1'b0, 1'b0, 7'h05, 32'h0);
        run_access(1'b0, 1'b0, 7'h05, 32'h0, lat, rd, en_cnt, other);
        e = sb.pop_front();
        n_run++; if (lat !== 2) begin n_fail++; $display("FAIL cpu_rd_latency got %0d want 2", lat); end
        n_run++; if (en_cnt !== 1) begin n_fail++; $display("FAIL cpu_rd_mem_en_cycles got %0d want 1", en_cnt); end
        n_run++; if (rd !== e.rdata) begin n_fail++; $display("FAIL cpu_rd_data got %h want %h", rd, e.rdata); end
    endtask

    task automatic test_mem0();
        int lat, en_cnt, other;
        logic [31:0] rd;
        exp_t e;
        push_exp(1'b1, 1'b1, 7'h00, 32'h0000000A);
        run_access(1'b1, 1'b1, 7'h00, 32'h0000000A, lat, rd, en_cnt, other);
        e = sb.pop_front();
        n_run++; if (lat !== 2 || other !== 0) begin n_fail++; $display("FAIL dbg_wr_ack got lat %0d cpu_acks %0d want 2/0", lat, other); end
        n_run++; if (bus.mem0_q !== 32'h0000000A) begin n_fail++; $display("FAIL mem0_dbg_write got %h want 0000000a", bus.mem0_q); end
        push_exp(1'b0, 1'b1, 7'h01, 32'h12345678);
        run_access(1'b0, 1'b1, 7'h01, 32'h12345678, lat, rd, en_cnt, other);
        e = sb.pop_front();
        n_run++; if (bus.mem0_q !== 32'h0000000A) begin n_fail++; $display("FAIL mem0_hold got %h want 0000000a", bus.mem0_q); end
    endtask

    task automatic test_arbitration();
        exp_t e;
        int got;
        bit own;
        for (int g = 0; g < 4; g++) begin
`ifdef ARB_ROUND_ROBIN_EN
            push_exp(g[0], 1'b0, g[0] ? 7'h00 : 7'h05, 32'h0);
`else
            push_exp(1'b0, 1'b0, 7'h05, 32'h0);
`endif
        end
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 7'h05;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 7'h00;
        for (int g = 0; g < 4; g++) begin
            got = 0;
            for (int i = 0; i < 10 && got == 0; i++) begin
                @(negedge clk);
                if (bus.cpu_ack || bus.dbg_ack) got = 1;
            end
            e = sb.pop_front();
            own = bus.dbg_ack;
            n_run++;
            if (got == 0) begin
                n_fail++; $display("FAIL arb_grant%0d no ack within bound", g);
            end else if (own !== e.dbg || bus.cpu_ack !== !e.dbg) begin
                n_fail++; $display("FAIL arb_grant%0d owner got cpu=%b dbg=%b want dbg=%b", g, bus.cpu_ack, bus.dbg_ack, e.dbg);
            end
            n_run++; if (got != 0 && bus.rdata !== e.rdata) begin n_fail++; $display("FAIL arb_grant%0d data got %h want %h", g, bus.rdata, e.rdata); end
        end
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 7'h00; bus.cpu_wdata = 32'h00000055;
        @(negedge clk);
        n_run++; if (bus.mem_en !== 1'b1) begin n_fail++; $display("FAIL rst_mid_issue got mem_en %b want 1", bus.mem_en); end
        rst_n = 1'b0;
        #1;
        n_run++; if (bus.mem_en !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_async got en %b busy %b want 0 0", bus.mem_en, bus.busy); end
        n_run++; if (bus.mem0_q !== 32'h0) begin n_fail++; $display("FAIL rst_mid_mem0 got %h want 0", bus.mem0_q); end
        @(negedge clk);
        bus.cpu_req = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.cpu_ack) acks++;
        end
        n_run++; if (acks !== 0) begin n_fail++; $display("FAIL rst_mid_no_ack got %0d acks want 0", acks); end
        n_run++; if (bus.mem0_q !== 32'h0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after got mem0 %h busy %b want 0 0", bus.mem0_q, bus.busy); end
    endtask

    task automatic test_early_drop();
        int acks = 0;
        int bad = 0;
        int got = 0;
        exp_t e;
        push_exp(1'b0, 1'b0, 7'h01, 32'h0);
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 7'h01;
        #1;
        n_run++; if (bus.cpu_stall !== 1'b1) begin n_fail++; $display("FAIL drop_stall_req got %b want 1", bus.cpu_stall); end
        @(negedge clk);
        bus.cpu_req = 1'b0;
        #1;
        n_run++; if (bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL drop_stall_idle got %b want 0", bus.cpu_stall); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.cpu_ack) begin
                acks++;
                e = sb.pop_front();
                n_run++; if (bus.rdata !== e.rdata) begin n_fail++; $display("FAIL drop_rdata got %h want %h", bus.rdata, e.rdata); end
            end
        end
        n_run++; if (acks !== 1) begin n_fail++; $display("FAIL drop_ack_count got %0d want 1", acks); end
        push_exp(1'b0, 1'b0, 7'h05, 32'h0);
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 7'h05;
        for (int i = 0; i < 10 && got == 0; i++) begin
            #1;
            if (bus.cpu_ack) begin
                got = 1;
                if (bus.cpu_stall !== 1'b0) bad++;
                e = sb.pop_front();
                n_run++; if (bus.rdata !== e.rdata) begin n_fail++; $display("FAIL hold_rdata got %h want %h", bus.rdata, e.rdata); end
            end else if (bus.cpu_stall !== 1'b1) bad++;
            if (got == 0) @(negedge clk);
        end
        bus.cpu_req = 1'b0;
        n_run++; if (got !== 1 || bad !== 0) begin n_fail++; $display("FAIL hold_stall got ack %0d stall_errs %0d want 1 0", got, bad); end
    endtask

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        test_reset();
        test_cpu_rw();
        test_mem0();
        test_arbitration();
        test_reset_mid();
        test_early_drop();
        n_run++; if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
